// File: rtl/syndrome_weight_ctrl.sv
// syndrome_weight_ctrl: sequences a shared popcount adder over syndrome chunks and accumulates the total weight.
// Define WEIGHT_THRESH_EN to add the thresh input and the registered above_thresh flag.
module syndrome_weight_ctrl #(
  parameter int S_LENGTH   = 256,
  parameter int NUM_CHUNKS = 4,
  parameter int SUM_BITS   = 9,
  parameter int ACC_BITS   = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [S_LENGTH*NUM_CHUNKS-1:0] syn_in,
  output logic                           busy,
  output logic [S_LENGTH-1:0]            chunk_data,
  output logic                           chunk_valid,
  input  logic [SUM_BITS-1:0]            chunk_sum,
  output logic [ACC_BITS-1:0]            weight,
  output logic                           weight_valid,
  output logic                           zero_syn
`ifdef WEIGHT_THRESH_EN
  ,
  input  logic [ACC_BITS-1:0]            thresh,
  output logic                           above_thresh
`endif
);
  localparam int IW = $clog2(NUM_CHUNKS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                         state;
  logic [S_LENGTH*NUM_CHUNKS-1:0] buffer;
  logic [IW-1:0]                  idx;
  logic [ACC_BITS-1:0]            acc, sum;
  logic                           last;
`ifdef WEIGHT_THRESH_EN
  logic [ACC_BITS-1:0]            thresh_q;
`endif
  assign sum         = acc + ACC_BITS'(chunk_sum);
  assign last        = idx == IW'(NUM_CHUNKS - 1);
  assign busy        = state != IDLE;
  assign chunk_valid = state == RUN;
  assign chunk_data  = chunk_valid ? buffer[idx*S_LENGTH +: S_LENGTH] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      buffer       <= '0;
      idx          <= '0;
      acc          <= '0;
      weight       <= '0;
      weight_valid <= 1'b0;
      zero_syn     <= 1'b0;
`ifdef WEIGHT_THRESH_EN
      thresh_q     <= '0;
      above_thresh <= 1'b0;
`endif
    end else begin
      weight_valid <= 1'b0;
      // abort only matters once a computation is in flight; weight/zero_syn keep the last result
      if (abort && state != IDLE) begin
        state <= IDLE;
        idx   <= '0;
        acc   <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            buffer <= syn_in;
            idx    <= '0;
            acc    <= '0;
            state  <= RUN;
`ifdef WEIGHT_THRESH_EN
            thresh_q <= thresh;
`endif
          end
          RUN: begin
            acc <= sum;
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
              weight       <= sum;
              zero_syn     <= sum == '0;
              weight_valid <= 1'b1;
              state        <= DONE;
`ifdef WEIGHT_THRESH_EN
              above_thresh <= sum > thresh_q;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_syndrome_weight_ctrl.sv
// tb_syndrome_weight_ctrl: randomized self-checking bench; the adder is a combinational popcount
// and the reference weight is the popcount of the whole syndrome.
module tb_syndrome_weight_ctrl;
  localparam int SL = 256, NC = 4, SB = 9, AB = 11, W = SL*NC;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [W-1:0]  syn_in = '0;
  logic          busy, chunk_valid, weight_valid, zero_syn;
  logic [SL-1:0] chunk_data;
  logic [SB-1:0] chunk_sum;
  logic [AB-1:0] weight;
  logic [AB-1:0] thr = '0;
`ifdef WEIGHT_THRESH_EN
  logic          above_thresh;
`endif
  int errors = 0, checks = 0;
  logic [AB-1:0] last_w = '0;
  logic          last_z = 1'b0;

  syndrome_weight_ctrl #(.S_LENGTH(SL), .NUM_CHUNKS(NC), .SUM_BITS(SB), .ACC_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .syn_in(syn_in), .busy(busy),
    .chunk_data(chunk_data), .chunk_valid(chunk_valid), .chunk_sum(chunk_sum),
    .weight(weight), .weight_valid(weight_valid), .zero_syn(zero_syn)
`ifdef WEIGHT_THRESH_EN
    , .thresh(thr), .above_thresh(above_thresh)
`endif
  );

  always #5 clk = ~clk;
  assign chunk_sum = SB'($countones(chunk_data));

  task automatic chk(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".weight"}, SL'(weight), '0);
    chk({tag, ".zero"}, SL'(zero_syn), '0);
    chk({tag, ".wv"}, SL'(weight_valid), '0);
    chk({tag, ".busy"}, SL'(busy), '0);
    chk({tag, ".cv"}, SL'(chunk_valid), '0);
    chk({tag, ".cd"}, chunk_data, '0);
`ifdef WEIGHT_THRESH_EN
    chk({tag, ".above"}, SL'(above_thresh), '0);
`endif
  endtask

  // Full computation; optionally re-pulse start (with other data/thresh) during RUN and DONE.
  task automatic run_check(input string tag, input logic [W-1:0] s, input logic [AB-1:0] th, input bit restart);
    int cv = 0, wv = 0, first_wv = 0, busy_n = 0;
    logic [AB-1:0] exp_w = AB'($countones(s));
    @(negedge clk);
    start = 1'b1; syn_in = s; thr = th;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start  = restart && (n == 2 || n == 5);
      syn_in = start ? ~s : s;
      thr    = start ? ~th : th;
      if (busy) busy_n++;
      if (chunk_valid) begin
        chk({tag, ".chunk"}, chunk_data, s[cv*SL +: SL]);
        cv++;
      end
      if (weight_valid) begin
        if (wv == 0) first_wv = n;
        wv++;
      end
    end
    chk({tag, ".lat"}, SL'(first_wv), SL'(NC + 1));
    chk({tag, ".nwv"}, SL'(wv), 1);
    chk({tag, ".ncv"}, SL'(cv), SL'(NC));
    chk({tag, ".busy"}, SL'(busy_n), SL'(NC + 1));
    chk({tag, ".weight"}, SL'(weight), SL'(exp_w));
    chk({tag, ".zero"}, SL'(zero_syn), SL'(exp_w == 0));
`ifdef WEIGHT_THRESH_EN
    chk({tag, ".above"}, SL'(above_thresh), SL'(exp_w > th));
`endif
    last_w = exp_w; last_z = exp_w == 0;
  endtask

  function automatic logic [W-1:0] rand_syn();
    logic [W-1:0] s = '0;
    case ($urandom_range(0, 3))
      0: for (int k = 0; k < int'($urandom_range(0, 12)); k++) s[$urandom_range(0, W-1)] = 1'b1;
      1: for (int k = 0; k < W/32; k++) s[k*32 +: 32] = $urandom;
      2: for (int k = 0; k < W/32; k++) s[k*32 +: 32] = $urandom & $urandom & $urandom;
      default: for (int k = 0; k < W/32; k++) s[k*32 +: 32] = ~($urandom & $urandom);
    endcase
    return s;
  endfunction

  initial begin
    logic [W-1:0] s;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");
    run_check("t1_zero", '0, '0, 1'b0);
    run_check("t2_134", W'(134), '0, 1'b0);
    run_check("t3_ones", '1, '0, 1'b0);
    s = '0;
    for (int k = 0; k < NC; k++) s[k*SL + SL - 1] = 1'b1;
    run_check("t3_msbs", s, '0, 1'b0);
    run_check("t4_restart", rand_syn(), AB'($urandom_range(0, W)), 1'b1);
    // abort in the second RUN cycle
    @(negedge clk);
    start = 1'b1; syn_in = rand_syn(); abort = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_abort.busy", SL'(busy), '0);
    chk("t5_abort.cv", SL'(chunk_valid), '0);
    begin
      int wv = 0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (weight_valid) wv++;
      end
      chk("t5_abort.nwv", SL'(wv), '0);
    end
    chk("t5_abort.weight", SL'(weight), SL'(last_w));
    chk("t5_abort.zero", SL'(zero_syn), SL'(last_z));
    run_check("t5_after_abort", rand_syn(), AB'($urandom_range(0, W)), 1'b0);
    // reset mid-RUN
    @(negedge clk);
    start = 1'b1; syn_in = rand_syn();
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_reset_outputs("t5_rst");
    begin
      int wv = 0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (weight_valid) wv++;
      end
      chk("t5_rst.nwv", SL'(wv), '0);
    end
    s = '0;
    for (int k = 0; k < 11; k++) s[k*90] = 1'b1;
    run_check("t6_thr10", s, AB'(10), 1'b0);
    run_check("t6_thr11", s, AB'(11), 1'b0);
    for (int r = 0; r < 12; r++) begin
      s = rand_syn();
      run_check($sformatf("rand%0d", r), s, AB'($countones(s)) + AB'($urandom_range(0, 2)) - 1'b1, r[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
